// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches words over a req/ack memory port and
// presents them to decode over valid/ready, with redirect support that cancels in-flight fetches.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ins,
  output logic        ins_valid,
  input  logic        ins_ready,
  output logic [31:0] ins_pc,
  output logic [31:0] pc_plus4,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        misalign
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    KILL  = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] req_addr;
  logic        redirect_odd;

  assign redirect_odd = redirect && (redirect_pc[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      req_addr <= RESET_PC;
      ins      <= '0;
      ins_pc   <= RESET_PC;
      misalign <= 1'b0;
    end else begin
      if (redirect_odd) misalign <= 1'b1;
      unique case (state)
        FETCH: begin
          if (redirect) begin
            pc <= redirect_pc;
            // A same-cycle ack closes the old request, so the new target can go out at once.
            if (imem_ack) req_addr <= redirect_pc;
            else          state    <= KILL;
          end else if (imem_ack) begin
            ins    <= imem_rdata;
            ins_pc <= req_addr;
            state  <= HOLD;
          end
        end
        KILL: begin
          if (redirect) pc <= redirect_pc;
          if (imem_ack) begin
            req_addr <= redirect ? redirect_pc : pc;
            state    <= FETCH;
          end
        end
        HOLD: begin
          if (redirect) begin
            pc       <= redirect_pc;
            req_addr <= redirect_pc;
            state    <= FETCH;
          end else if (ins_ready) begin
            pc       <= ins_pc + PC_STEP;
            req_addr <= ins_pc + PC_STEP;
            state    <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

  assign imem_req  = ((state == FETCH) || (state == KILL)) && !reset;
  assign imem_addr = req_addr;
  assign ins_valid = (state == HOLD);
  assign pc_plus4  = ins_pc + PC_STEP;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit; inputs driven and outputs checked on the falling edge.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] ins;
  logic        ins_valid;
  logic        ins_ready;
  logic [31:0] ins_pc;
  logic [31:0] pc_plus4;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        misalign;

  int unsigned nc = 0;
  int unsigned nf = 0;

  fetch_unit #(.RESET_PC(32'h0000_0000), .PC_STEP(32'd4)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .ins(ins), .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_pc(ins_pc), .pc_plus4(pc_plus4),
    .redirect(redirect), .redirect_pc(redirect_pc), .misalign(misalign)
  );

  always #5 clk = ~clk;

  // Leaves the DUT in FETCH at RESET_PC with all inputs idle, positioned at a falling edge.
  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1; imem_ack = 1'b0; redirect = 1'b0; ins_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; imem_ack = 1'b0; imem_rdata = '0; ins_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    @(negedge clk); @(negedge clk);
    nc++; if (imem_req !== 1'b0) begin nf++; $display("FAIL rst_req got=%h exp=0", imem_req); end
    nc++; if (ins_valid !== 1'b0) begin nf++; $display("FAIL rst_valid got=%h exp=0", ins_valid); end
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_0000;
    @(negedge clk);
    nc++; if (ins_valid !== 1'b0) begin nf++; $display("FAIL rst_ack_dropped got=%h exp=0", ins_valid); end
    reset = 1'b0; imem_rdata = 32'hA5A5_0000;
    #1;
    nc++; if (imem_req !== 1'b1) begin nf++; $display("FAIL first_req got=%h exp=1", imem_req); end
    nc++; if (imem_addr !== 32'h0) begin nf++; $display("FAIL first_addr got=%h exp=0", imem_addr); end
    nc++; if (misalign !== 1'b0) begin nf++; $display("FAIL rst_misalign got=%h exp=0", misalign); end
    nc++; if (ins !== 32'h0) begin nf++; $display("FAIL rst_ins got=%h exp=0", ins); end
    nc++; if (ins_pc !== 32'h0) begin nf++; $display("FAIL rst_ins_pc got=%h exp=0", ins_pc); end
    @(negedge clk);
    imem_ack = 1'b0;
    nc++; if (ins_valid !== 1'b1) begin nf++; $display("FAIL zw_valid got=%h exp=1", ins_valid); end
    nc++; if (ins !== 32'hA5A5_0000) begin nf++; $display("FAIL zw_ins got=%h exp=a5a50000", ins); end
    nc++; if (ins_pc !== 32'h0) begin nf++; $display("FAIL zw_ins_pc got=%h exp=0", ins_pc); end
    nc++; if (pc_plus4 !== 32'h4) begin nf++; $display("FAIL zw_pc_plus4 got=%h exp=4", pc_plus4); end
    nc++; if (imem_req !== 1'b0) begin nf++; $display("FAIL zw_req_hold got=%h exp=0", imem_req); end
  endtask

  task automatic test_wait_ack();
    logic [31:0] ea;
    apply_reset();
    ins_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ea = 32'(i) * 32'd4;
      imem_ack = 1'b0;
      #1;
      nc++; if (imem_addr !== ea || imem_req !== 1'b1) begin nf++; $display("FAIL wait_addr1[%0d] got=%h/%h exp=%h/1", i, imem_addr, imem_req, ea); end
      @(negedge clk);
      nc++; if (imem_addr !== ea || imem_req !== 1'b1) begin nf++; $display("FAIL wait_addr2[%0d] got=%h/%h exp=%h/1", i, imem_addr, imem_req, ea); end
      imem_ack = 1'b1; imem_rdata = 32'hC000_0000 + 32'(i);
      @(negedge clk);
      imem_ack = 1'b0;
      nc++; if (ins_valid !== 1'b1 || ins_pc !== ea) begin nf++; $display("FAIL wait_ins_pc[%0d] got=%h/%h exp=1/%h", i, ins_valid, ins_pc, ea); end
      nc++; if (ins !== 32'hC000_0000 + 32'(i)) begin nf++; $display("FAIL wait_ins[%0d] got=%h exp=%h", i, ins, 32'hC000_0000 + 32'(i)); end
      @(negedge clk);
    end
    ins_ready = 1'b0;
  endtask

  task automatic test_hold_stall();
    apply_reset();
    imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    @(negedge clk);
    imem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      nc++; if (ins !== 32'h1234_5678 || ins_pc !== 32'h0 || ins_valid !== 1'b1) begin nf++; $display("FAIL stall_ins[%0d] got=%h/%h/%h exp=12345678/0/1", i, ins, ins_pc, ins_valid); end
      nc++; if (imem_req !== 1'b0) begin nf++; $display("FAIL stall_req[%0d] got=%h exp=0", i, imem_req); end
      @(negedge clk);
    end
    ins_ready = 1'b1;
    @(negedge clk);
    ins_ready = 1'b0;
    nc++; if (imem_req !== 1'b1 || imem_addr !== 32'h4 || ins_valid !== 1'b0) begin nf++; $display("FAIL stall_next got=%h/%h/%h exp=1/4/0", imem_req, imem_addr, ins_valid); end
  endtask

  task automatic test_redirect_hold();
    apply_reset();
    imem_ack = 1'b1; imem_rdata = 32'h0000_AAAA;
    @(negedge clk);
    imem_ack = 1'b0; redirect = 1'b1; redirect_pc = 32'h40;
    @(negedge clk);
    redirect = 1'b0;
    nc++; if (ins_valid !== 1'b0) begin nf++; $display("FAIL rdh_valid got=%h exp=0", ins_valid); end
    nc++; if (imem_addr !== 32'h40 || imem_req !== 1'b1) begin nf++; $display("FAIL rdh_addr got=%h/%h exp=40/1", imem_addr, imem_req); end
    imem_ack = 1'b1; imem_rdata = 32'h0000_BBBB;
    @(negedge clk);
    imem_ack = 1'b0;
    nc++; if (ins_valid !== 1'b1 || ins_pc !== 32'h40 || ins !== 32'h0000_BBBB) begin nf++; $display("FAIL rdh_ins got=%h/%h/%h exp=1/40/0000bbbb", ins_valid, ins_pc, ins); end
    nc++; if (misalign !== 1'b0) begin nf++; $display("FAIL rdh_misalign got=%h exp=0", misalign); end
    redirect = 1'b1; redirect_pc = 32'h60; ins_ready = 1'b1;
    @(negedge clk);
    redirect = 1'b0; ins_ready = 1'b0;
    nc++; if (imem_addr !== 32'h60 || ins_valid !== 1'b0) begin nf++; $display("FAIL rdh_prio got=%h/%h exp=60/0", imem_addr, ins_valid); end
  endtask

  task automatic test_redirect_wait();
    apply_reset();
    redirect = 1'b1; redirect_pc = 32'h80;
    @(negedge clk);
    redirect = 1'b0;
    for (int i = 0; i < 2; i++) begin
      nc++; if (imem_addr !== 32'h0 || imem_req !== 1'b1 || ins_valid !== 1'b0) begin nf++; $display("FAIL kill_wait[%0d] got=%h/%h/%h exp=0/1/0", i, imem_addr, imem_req, ins_valid); end
      if (i == 1) begin imem_ack = 1'b1; imem_rdata = 32'hBAD0_0001; end
      @(negedge clk);
    end
    imem_ack = 1'b0;
    nc++; if (ins_valid !== 1'b0 || imem_addr !== 32'h80 || imem_req !== 1'b1) begin nf++; $display("FAIL kill_drop got=%h/%h/%h exp=0/80/1", ins_valid, imem_addr, imem_req); end
    imem_ack = 1'b1; imem_rdata = 32'h6000_0080;
    @(negedge clk);
    imem_ack = 1'b0;
    nc++; if (ins_valid !== 1'b1 || ins !== 32'h6000_0080 || ins_pc !== 32'h80) begin nf++; $display("FAIL kill_fetch got=%h/%h/%h exp=1/60000080/80", ins_valid, ins, ins_pc); end
    ins_ready = 1'b1;
    @(negedge clk);
    ins_ready = 1'b0;
    imem_ack = 1'b1; imem_rdata = 32'hBAD0_0002; redirect = 1'b1; redirect_pc = 32'h82;
    @(negedge clk);
    imem_ack = 1'b0; redirect = 1'b0;
    nc++; if (ins_valid !== 1'b0 || imem_addr !== 32'h82 || imem_req !== 1'b1) begin nf++; $display("FAIL ack_rd_drop got=%h/%h/%h exp=0/82/1", ins_valid, imem_addr, imem_req); end
    nc++; if (misalign !== 1'b1) begin nf++; $display("FAIL misalign_set got=%h exp=1", misalign); end
    imem_ack = 1'b1; imem_rdata = 32'h6000_0082;
    @(negedge clk);
    imem_ack = 1'b0;
    nc++; if (ins_pc !== 32'h82 || ins !== 32'h6000_0082 || pc_plus4 !== 32'h86) begin nf++; $display("FAIL odd_fetch got=%h/%h/%h exp=82/60000082/86", ins_pc, ins, pc_plus4); end
  endtask

  task automatic test_kill_chain();
    apply_reset();
    #1;
    nc++; if (misalign !== 1'b0) begin nf++; $display("FAIL misalign_clr got=%h exp=0", misalign); end
    redirect = 1'b1; redirect_pc = 32'h100;
    @(negedge clk);
    redirect_pc = 32'h200; imem_ack = 1'b1; imem_rdata = 32'hBAD0_0003;
    @(negedge clk);
    redirect = 1'b0; imem_ack = 1'b0;
    nc++; if (imem_addr !== 32'h200 || ins_valid !== 1'b0 || imem_req !== 1'b1) begin nf++; $display("FAIL kill_latest got=%h/%h/%h exp=200/0/1", imem_addr, ins_valid, imem_req); end
  endtask

  task automatic test_reset_midwait();
    apply_reset();
    imem_ack = 1'b1; imem_rdata = 32'h0000_0001;
    @(negedge clk);
    imem_ack = 1'b0; ins_ready = 1'b1;
    @(negedge clk);
    ins_ready = 1'b0;
    @(negedge clk);
    nc++; if (imem_addr !== 32'h4 || imem_req !== 1'b1) begin nf++; $display("FAIL mid_wait got=%h/%h exp=4/1", imem_addr, imem_req); end
    reset = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hBAD0_0004;
    @(negedge clk);
    nc++; if (imem_req !== 1'b0 || ins_valid !== 1'b0) begin nf++; $display("FAIL mid_rst got=%h/%h exp=0/0", imem_req, ins_valid); end
    reset = 1'b0; imem_ack = 1'b0;
    @(negedge clk);
    nc++; if (imem_addr !== 32'h0 || imem_req !== 1'b1 || ins_valid !== 1'b0) begin nf++; $display("FAIL mid_restart got=%h/%h/%h exp=0/1/0", imem_addr, imem_req, ins_valid); end
  endtask

  task automatic test_wrap();
    apply_reset();
    imem_ack = 1'b1; imem_rdata = 32'h0;
    @(negedge clk);
    imem_ack = 1'b0; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect = 1'b0;
    nc++; if (imem_addr !== 32'hFFFF_FFFC) begin nf++; $display("FAIL wrap_addr got=%h exp=fffffffc", imem_addr); end
    imem_ack = 1'b1; imem_rdata = 32'h7777_7777;
    @(negedge clk);
    imem_ack = 1'b0;
    nc++; if (ins_pc !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0) begin nf++; $display("FAIL wrap_link got=%h/%h exp=fffffffc/0", ins_pc, pc_plus4); end
    ins_ready = 1'b1;
    @(negedge clk);
    ins_ready = 1'b0;
    nc++; if (imem_addr !== 32'h0 || imem_req !== 1'b1) begin nf++; $display("FAIL wrap_next got=%h/%h exp=0/1", imem_addr, imem_req); end
  endtask

  initial begin
    test_reset();
    test_wait_ack();
    test_hold_stall();
    test_redirect_hold();
    test_redirect_wait();
    test_kill_chain();
    test_reset_midwait();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nc, nf);
    $finish;
  end

endmodule
